nanosoc_bootrom_arbiter: RTL and testbench

Two-manager AHB-lite arbiter placed in front of the nanosoc bootrom region (0x10000000 aliased at 0x00000000). It shares the bootrom between the CPU (M0) and the debug/loader manager (M1). Uncontended requests pass through with zero added latency. A manager that loses arbitration has its address phase buffered and replayed, and its data phase is stalled until the replayed transfer completes.

---
 rtl/nanosoc_bootrom_arb_pkg.sv | 11 +
 rtl/nanosoc_bootrom_arb_port.sv | 63 ++++++
 rtl/nanosoc_bootrom_arbiter.sv | 105 ++++++++++
 tb/tb_nanosoc_bootrom_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanosoc_bootrom_arb_pkg.sv
// nanosoc_bootrom_arb_pkg: shared HTRANS codes, port FSM states and grant encodings
package nanosoc_bootrom_arb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DATA} port_state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;
endpackage

// File: rtl/nanosoc_bootrom_arb_port.sv
// nanosoc_bootrom_arb_port: per-manager FSM, address-phase holding register and response mux
module nanosoc_bootrom_arb_port
  import nanosoc_bootrom_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsel_i,
  input  logic [AW-1:0] haddr_i,
  input  logic [1:0]    htrans_i,
  input  logic [2:0]    hsize_i,
  input  logic [3:0]    hprot_i,
  input  logic          hwrite_i,
  input  logic          hready_i,
  input  logic          gnt_i,
  input  logic          own_i,
  input  logic          s_hreadyout_i,
  input  logic          s_hresp_i,
  input  logic [DW-1:0] s_hrdata_i,
  output logic          req_o,
  output logic [AW-1:0] haddr_o,
  output logic [1:0]    htrans_o,
  output logic [2:0]    hsize_o,
  output logic [3:0]    hprot_o,
  output logic          hwrite_o,
  output logic          hreadyout_o,
  output logic          hresp_o,
  output logic [DW-1:0] hrdata_o
);
  localparam int HW = AW + 10;
  port_state_t   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d, live;
  logic          live_req, pend, take;
  assign live     = {haddr_i, htrans_i, hsize_i, hprot_i, hwrite_i};
  assign live_req = hsel_i & htrans_i[1] & hready_i;
  assign pend     = state_q == ST_PEND;
  assign req_o    = pend | live_req;
  assign {haddr_o, htrans_o, hsize_o, hprot_o, hwrite_o} = pend ? hold_q : live;
  assign hreadyout_o = own_i ? s_hreadyout_i : state_q == ST_IDLE;
  assign hresp_o     = own_i & s_hresp_i;
  assign hrdata_o    = own_i ? s_hrdata_i : '0;
  assign take        = (state_q == ST_IDLE) | (state_q == ST_DATA & hreadyout_o);
  // a held request waits for its grant; a new live request is only accepted when the port is free
  always_comb begin
    state_d = pend ? (gnt_i ? ST_DATA : ST_PEND) :
              !take ? state_q :
              !live_req ? ST_IDLE :
              gnt_i ? ST_DATA : ST_PEND;
    hold_d  = (take & live_req & !gnt_i) ? live : hold_q;
  end
  // state and holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: rtl/nanosoc_bootrom_arbiter.sv
// nanosoc_bootrom_arbiter: two-manager AHB-lite bootrom arbiter; NANOSOC_BOOTROM_ARB_RR_EN selects round-robin over fixed M0 priority
module nanosoc_bootrom_arbiter
  import nanosoc_bootrom_arb_pkg::*;
#(
  parameter int SYS_ADDR_W = 32,
  parameter int SYS_DATA_W = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  M0_HSEL,
  input  logic [SYS_ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]            M0_HTRANS,
  input  logic [2:0]            M0_HSIZE,
  input  logic [3:0]            M0_HPROT,
  input  logic                  M0_HWRITE,
  input  logic                  M0_HREADY,
  input  logic [SYS_DATA_W-1:0] M0_HWDATA,
  output logic                  M0_HREADYOUT,
  output logic                  M0_HRESP,
  output logic [SYS_DATA_W-1:0] M0_HRDATA,
  input  logic                  M1_HSEL,
  input  logic [SYS_ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]            M1_HTRANS,
  input  logic [2:0]            M1_HSIZE,
  input  logic [3:0]            M1_HPROT,
  input  logic                  M1_HWRITE,
  input  logic                  M1_HREADY,
  input  logic [SYS_DATA_W-1:0] M1_HWDATA,
  output logic                  M1_HREADYOUT,
  output logic                  M1_HRESP,
  output logic [SYS_DATA_W-1:0] M1_HRDATA,
  output logic                  S_HSEL,
  output logic [SYS_ADDR_W-1:0] S_HADDR,
  output logic [1:0]            S_HTRANS,
  output logic [2:0]            S_HSIZE,
  output logic [3:0]            S_HPROT,
  output logic                  S_HWRITE,
  output logic                  S_HREADY,
  output logic [SYS_DATA_W-1:0] S_HWDATA,
  input  logic                  S_HREADYOUT,
  input  logic                  S_HRESP,
  input  logic [SYS_DATA_W-1:0] S_HRDATA
);
  logic [1:0]            req, gnt, dsel_q, dsel_d, trans0, trans1;
  logic [SYS_ADDR_W-1:0] addr0, addr1;
  logic [2:0]            size0, size1;
  logic [3:0]            prot0, prot1;
  logic                  write0, write1, lock0, lock1, pick1;
  nanosoc_bootrom_arb_port #(.AW(SYS_ADDR_W), .DW(SYS_DATA_W)) u_m0 (
    .clk(HCLK), .rst(HRESET),
    .hsel_i(M0_HSEL), .haddr_i(M0_HADDR), .htrans_i(M0_HTRANS), .hsize_i(M0_HSIZE),
    .hprot_i(M0_HPROT), .hwrite_i(M0_HWRITE), .hready_i(M0_HREADY),
    .gnt_i(gnt[0]), .own_i(dsel_q[0]),
    .s_hreadyout_i(S_HREADYOUT), .s_hresp_i(S_HRESP), .s_hrdata_i(S_HRDATA),
    .req_o(req[0]), .haddr_o(addr0), .htrans_o(trans0), .hsize_o(size0),
    .hprot_o(prot0), .hwrite_o(write0),
    .hreadyout_o(M0_HREADYOUT), .hresp_o(M0_HRESP), .hrdata_o(M0_HRDATA)
  );
  nanosoc_bootrom_arb_port #(.AW(SYS_ADDR_W), .DW(SYS_DATA_W)) u_m1 (
    .clk(HCLK), .rst(HRESET),
    .hsel_i(M1_HSEL), .haddr_i(M1_HADDR), .htrans_i(M1_HTRANS), .hsize_i(M1_HSIZE),
    .hprot_i(M1_HPROT), .hwrite_i(M1_HWRITE), .hready_i(M1_HREADY),
    .gnt_i(gnt[1]), .own_i(dsel_q[1]),
    .s_hreadyout_i(S_HREADYOUT), .s_hresp_i(S_HRESP), .s_hrdata_i(S_HRDATA),
    .req_o(req[1]), .haddr_o(addr1), .htrans_o(trans1), .hsize_o(size1),
    .hprot_o(prot1), .hwrite_o(write1),
    .hreadyout_o(M1_HREADYOUT), .hresp_o(M1_HRESP), .hrdata_o(M1_HRDATA)
  );
`ifdef NANOSOC_BOOTROM_ARB_RR_EN
  logic ptr_q, ptr_d;
  // pointer favours the port that lost the last NONSEQ grant
  always_comb ptr_d = (|gnt && (gnt[0] ? trans0 : trans1) == HTRANS_NONSEQ) ? gnt[0] : ptr_q;
  // round-robin pointer, reset favouring M0
  always_ff @(posedge HCLK) begin
    if (HRESET) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
`endif
  // grant only while the bootrom is ready; an ongoing SEQ burst keeps its owner
  always_comb begin
    lock0 = dsel_q[0] & req[0] & (trans0 == HTRANS_SEQ);
    lock1 = dsel_q[1] & req[1] & (trans1 == HTRANS_SEQ);
`ifdef NANOSOC_BOOTROM_ARB_RR_EN
    pick1 = req[1] & (~req[0] | ptr_q);
`else
    pick1 = req[1] & ~req[0];
`endif
    gnt    = !S_HREADYOUT ? GNT_NONE : lock0 ? GNT_M0 : lock1 ? GNT_M1 :
             pick1 ? GNT_M1 : req[0] ? GNT_M0 : GNT_NONE;
    dsel_d = S_HREADYOUT ? gnt : dsel_q;
  end
  // data-phase owner follows the address owner whenever the bootrom completes a phase
  always_ff @(posedge HCLK) begin
    if (HRESET) dsel_q <= GNT_NONE;
    else dsel_q <= dsel_d;
  end
  assign S_HSEL   = |gnt;
  assign S_HADDR  = gnt[1] ? addr1  : gnt[0] ? addr0  : '0;
  assign S_HTRANS = gnt[1] ? trans1 : gnt[0] ? trans0 : HTRANS_IDLE;
  assign S_HSIZE  = gnt[1] ? size1  : gnt[0] ? size0  : '0;
  assign S_HPROT  = gnt[1] ? prot1  : gnt[0] ? prot0  : '0;
  assign S_HWRITE = gnt[1] ? write1 : gnt[0] & write0;
  assign S_HREADY = S_HREADYOUT;
  assign S_HWDATA = dsel_q[1] ? M1_HWDATA : dsel_q[0] ? M0_HWDATA : '0;
endmodule

// File: tb/tb_nanosoc_bootrom_arbiter.sv
// tb_nanosoc_bootrom_arbiter: vector table plus directed multi-cycle sequences against a small bootrom model
module tb_nanosoc_bootrom_arbiter;
  localparam logic [1:0] NS = 2'b10, SQ = 2'b11, BZ = 2'b01, ID = 2'b00;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic m0_sel, m0_write, m1_sel, m1_write;
  logic [1:0] m0_trans, m1_trans;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic m0_rdy, m0_resp, m1_rdy, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_hsel, s_hwrite, s_hready, s_rdy, s_resp;
  logic [31:0] s_haddr, s_hwdata, s_rdata;
  logic [1:0] s_htrans;
  logic [2:0] s_hsize;
  logic [3:0] s_hprot;
  int total = 0, bad = 0;
  nanosoc_bootrom_arbiter dut (
    .HCLK(clk), .HRESET(rst),
    .M0_HSEL(m0_sel), .M0_HADDR(m0_addr), .M0_HTRANS(m0_trans), .M0_HSIZE(3'b010),
    .M0_HPROT(4'b0011), .M0_HWRITE(m0_write), .M0_HREADY(m0_rdy), .M0_HWDATA(m0_wdata),
    .M0_HREADYOUT(m0_rdy), .M0_HRESP(m0_resp), .M0_HRDATA(m0_rdata),
    .M1_HSEL(m1_sel), .M1_HADDR(m1_addr), .M1_HTRANS(m1_trans), .M1_HSIZE(3'b010),
    .M1_HPROT(4'b0011), .M1_HWRITE(m1_write), .M1_HREADY(m1_rdy), .M1_HWDATA(m1_wdata),
    .M1_HREADYOUT(m1_rdy), .M1_HRESP(m1_resp), .M1_HRDATA(m1_rdata),
    .S_HSEL(s_hsel), .S_HADDR(s_haddr), .S_HTRANS(s_htrans), .S_HSIZE(s_hsize),
    .S_HPROT(s_hprot), .S_HWRITE(s_hwrite), .S_HREADY(s_hready), .S_HWDATA(s_hwdata),
    .S_HREADYOUT(s_rdy), .S_HRESP(s_resp), .S_HRDATA(s_rdata)
  );
  int ws = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic sv_act = 1'b0, sv_wr = 1'b0, sv_err = 1'b0;
  int sv_cnt = 0;
  logic [1:0] sv_ph = 2'd0;
  logic [31:0] sv_addr = '0, last_wdata = '0;
  logic [31:0] acc_q[$];
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h40 ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
  endfunction
  assign s_rdy   = !sv_act | (sv_err ? sv_ph == 2'd2 : sv_cnt == 0);
  assign s_resp  = sv_act & sv_err;
  assign s_rdata = (sv_act & !sv_err & !sv_wr & sv_cnt == 0) ? rom(sv_addr) : '0;
  always @(posedge clk) begin
    if (rst) sv_act <= 1'b0;
    else if (s_hready) begin
      if (sv_act & sv_wr & !sv_err) last_wdata <= s_hwdata;
      if (s_hsel & s_htrans[1]) begin
        sv_act  <= 1'b1;
        sv_addr <= s_haddr;
        sv_wr   <= s_hwrite;
        sv_cnt  <= ws;
        sv_err  <= s_haddr == err_addr;
        sv_ph   <= 2'd1;
        acc_q.push_back(s_haddr);
      end else sv_act <= 1'b0;
    end else begin
      if (sv_cnt > 0) sv_cnt <= sv_cnt - 1;
      sv_ph <= 2'd2;
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all;
    m0_sel = 0; m0_trans = ID; m0_write = 0;
    m1_sel = 0; m1_trans = ID; m1_write = 0;
  endtask
  task automatic do_reset;
    rst = 1;
    idle_all;
    tick;
    rst = 0;
  endtask
  typedef struct {
    logic s0; logic [1:0] t0; logic [31:0] a0;
    logic s1; logic [1:0] t1; logic [31:0] a1;
    logic eh; logic [1:0] et; logic [31:0] ea;
  } vec_t;
  vec_t tbl[8];
  logic [31:0] exp_b[5];
  int n80;
  initial begin
    tbl[0] = '{1'b0, ID, 32'h0,    1'b0, ID, 32'h0,    1'b0, ID, 32'h0};
    tbl[1] = '{1'b1, NS, 32'h1000, 1'b0, ID, 32'h0,    1'b1, NS, 32'h1000};
    tbl[2] = '{1'b0, ID, 32'h0,    1'b1, NS, 32'h2000, 1'b1, NS, 32'h2000};
    tbl[3] = '{1'b0, NS, 32'h1004, 1'b0, ID, 32'h0,    1'b0, ID, 32'h0};
    tbl[4] = '{1'b1, BZ, 32'h1008, 1'b0, ID, 32'h0,    1'b0, ID, 32'h0};
    tbl[5] = '{1'b1, NS, 32'h100C, 1'b1, NS, 32'h200C, 1'b1, NS, 32'h100C};
    tbl[6] = '{1'b1, ID, 32'h1010, 1'b1, NS, 32'h2010, 1'b1, NS, 32'h2010};
    tbl[7] = '{1'b0, ID, 32'h0,    1'b1, SQ, 32'h3000, 1'b1, SQ, 32'h3000};
    exp_b  = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200};
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    do_reset;
    do_reset;
    @(negedge clk);
    chk("rst m0_rdy", {31'b0, m0_rdy}, 1);
    chk("rst m1_rdy", {31'b0, m1_rdy}, 1);
    chk("rst m0_resp", {31'b0, m0_resp}, 0);
    chk("rst m1_rdata", m1_rdata, 0);
    chk("rst s_hsel", {31'b0, s_hsel}, 0);
    chk("rst s_htrans", {30'b0, s_htrans}, 0);
    for (int i = 0; i < 8; i++) begin
      do_reset;
      m0_sel = tbl[i].s0; m0_trans = tbl[i].t0; m0_addr = tbl[i].a0;
      m1_sel = tbl[i].s1; m1_trans = tbl[i].t1; m1_addr = tbl[i].a1;
      @(negedge clk);
      chk($sformatf("vec%0d hsel", i), {31'b0, s_hsel}, {31'b0, tbl[i].eh});
      chk($sformatf("vec%0d htrans", i), {30'b0, s_htrans}, {30'b0, tbl[i].et});
      chk($sformatf("vec%0d haddr", i), s_haddr, tbl[i].ea);
    end
    do_reset;
    ws = 0;
    m0_sel = 1; m0_trans = NS; m0_addr = 32'h40;
    @(negedge clk);
    chk("single s_hsel", {31'b0, s_hsel}, 1);
    chk("single s_haddr", s_haddr, 32'h40);
    tick;
    idle_all;
    @(negedge clk);
    chk("single m0_rdy", {31'b0, m0_rdy}, 1);
    chk("single m0_rdata", m0_rdata, 32'h1234_5678);
    chk("single m1_rdy", {31'b0, m1_rdy}, 1);
    do_reset;
    for (int k = 0; k < 4; k++) begin
      m0_sel = 1; m0_trans = NS; m0_addr = 32'h10;
      m1_sel = 1; m1_trans = NS; m1_addr = 32'h20;
      @(negedge clk);
      chk($sformatf("dual%0d first", k), s_haddr, 32'h10);
      tick;
      idle_all;
      @(negedge clk);
      chk($sformatf("dual%0d m0_rdata", k), m0_rdata, rom(32'h10));
      chk($sformatf("dual%0d m1_stall", k), {31'b0, m1_rdy}, 0);
      chk($sformatf("dual%0d second", k), s_haddr, 32'h20);
      tick;
      @(negedge clk);
      chk($sformatf("dual%0d m1_rdy", k), {31'b0, m1_rdy}, 1);
      chk($sformatf("dual%0d m1_rdata", k), m1_rdata, rom(32'h20));
      tick;
    end
    do_reset;
    m0_sel = 1; m0_trans = NS; m0_addr = 32'h10;
    m1_sel = 1; m1_trans = NS; m1_addr = 32'h20;
    tick;
    m1_sel = 0; m1_trans = ID;
    m0_addr = 32'h14;
    @(negedge clk);
    chk("sat m1_rdy", {31'b0, m1_rdy}, 0);
`ifdef NANOSOC_BOOTROM_ARB_RR_EN
    chk("sat second", s_haddr, 32'h20);
`else
    chk("sat second", s_haddr, 32'h14);
`endif
    tick;
    idle_all;
    @(negedge clk);
`ifdef NANOSOC_BOOTROM_ARB_RR_EN
    chk("sat third", s_haddr, 32'h14);
`else
    chk("sat third", s_haddr, 32'h20);
`endif
    tick;
    tick;
    do_reset;
    acc_q.delete();
    m0_sel = 1; m0_trans = NS; m0_addr = 32'h100;
    tick;
    m0_trans = SQ; m0_addr = 32'h104;
    m1_sel = 1; m1_trans = NS; m1_addr = 32'h200;
    @(negedge clk);
    chk("burst beat2", s_haddr, 32'h104);
    tick;
    m1_sel = 0; m1_trans = ID;
    m0_addr = 32'h108;
    @(negedge clk);
    chk("burst m1 wait", {31'b0, m1_rdy}, 0);
    tick;
    m0_addr = 32'h10C;
    @(negedge clk);
    chk("burst beat4", s_haddr, 32'h10C);
    tick;
    idle_all;
    @(negedge clk);
    chk("burst m1 addr", s_haddr, 32'h200);
    chk("burst m0 last", m0_rdata, rom(32'h10C));
    tick;
    @(negedge clk);
    chk("burst m1_rdy", {31'b0, m1_rdy}, 1);
    chk("burst m1_rdata", m1_rdata, rom(32'h200));
    chk("burst count", acc_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("burst seq%0d", i), acc_q.size() > i ? acc_q[i] : 32'hBAD0_BAD0, exp_b[i]);
    do_reset;
    err_addr = 32'h300;
    m1_sel = 1; m1_trans = NS; m1_addr = 32'h300;
    tick;
    m1_sel = 0; m1_trans = ID;
    m0_sel = 1; m0_trans = NS; m0_addr = 32'h44;
    @(negedge clk);
    chk("err1 m1_resp", {31'b0, m1_resp}, 1);
    chk("err1 m1_rdy", {31'b0, m1_rdy}, 0);
    chk("err1 s_hsel", {31'b0, s_hsel}, 0);
    tick;
    idle_all;
    @(negedge clk);
    chk("err2 m1_resp", {31'b0, m1_resp}, 1);
    chk("err2 m1_rdy", {31'b0, m1_rdy}, 1);
    chk("err2 m0_rdy", {31'b0, m0_rdy}, 0);
    chk("err2 s_haddr", s_haddr, 32'h44);
    tick;
    @(negedge clk);
    chk("err3 m0_rdy", {31'b0, m0_rdy}, 1);
    chk("err3 m0_resp", {31'b0, m0_resp}, 0);
    chk("err3 m0_rdata", m0_rdata, rom(32'h44));
    err_addr = 32'hFFFF_FFFF;
    do_reset;
    ws = 2;
    m0_sel = 1; m0_trans = NS; m0_addr = 32'h50;
    tick;
    m0_sel = 0; m0_trans = ID;
    m1_sel = 1; m1_trans = NS; m1_addr = 32'h60; m1_write = 1;
    ws = 0;
    @(negedge clk);
    chk("wr s_hsel busy", {31'b0, s_hsel}, 0);
    tick;
    idle_all;
    m1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr m1 stall", {31'b0, m1_rdy}, 0);
    tick;
    @(negedge clk);
    chk("wr replay addr", s_haddr, 32'h60);
    chk("wr replay write", {31'b0, s_hwrite}, 1);
    chk("wr m1 still", {31'b0, m1_rdy}, 0);
    tick;
    @(negedge clk);
    chk("wr s_hwdata", s_hwdata, 32'hDEAD_BEEF);
    chk("wr m1_rdy", {31'b0, m1_rdy}, 1);
    tick;
    chk("wr captured", last_wdata, 32'hDEAD_BEEF);
    m1_wdata = 0;
    do_reset;
    acc_q.delete();
    ws = 2;
    m0_sel = 1; m0_trans = NS; m0_addr = 32'h70;
    tick;
    m0_sel = 0; m0_trans = ID;
    m1_sel = 1; m1_trans = NS; m1_addr = 32'h80;
    ws = 0;
    tick;
    idle_all;
    rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    chk("hrst m0_rdy", {31'b0, m0_rdy}, 1);
    chk("hrst m1_rdy", {31'b0, m1_rdy}, 1);
    chk("hrst m1_resp", {31'b0, m1_resp}, 0);
    chk("hrst m0_rdata", m0_rdata, 0);
    chk("hrst s_hsel", {31'b0, s_hsel}, 0);
    chk("hrst s_htrans", {30'b0, s_htrans}, 0);
    repeat (4) tick;
    n80 = 0;
    foreach (acc_q[i]) if (acc_q[i] == 32'h80) n80++;
    chk("hrst held dropped", n80, 0);
    chk("hrst issued", acc_q.size(), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
